// File: rtl/gravador_mapa.sv
// gravador_mapa: map editor for the 16x4 obstacle RAM.
// Moves a cursor over N_COLUNAS columns x 4 lanes and toggles the bit under
// it with a read-modify-write. It can also clear the whole map in a sweep.
// Ports:
//   clock, reset (async, active-low)
//   iniciar_edicao, controle_vertical[1:0], controle_horizontal[1:0],
//   confirma, limpar, finalizar : level inputs, acted on at rising edges
//   q_ram[3:0]                  : RAM read data (1-cycle latency)
//   ram_addr, ram_data, ram_we  : RAM write-side pins
//   cursor_coluna, cursor_linha : cursor position
//   editando, pronto, db_estado : status and debug state code
module gravador_mapa #(
    parameter int unsigned N_COLUNAS      = 16,
    parameter bit          PROTEGE_INICIO = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar_edicao,
    input  logic [1:0] controle_vertical,
    input  logic [1:0] controle_horizontal,
    input  logic       confirma,
    input  logic       limpar,
    input  logic       finalizar,
    input  logic [3:0] q_ram,
    output logic [3:0] ram_addr,
    output logic [3:0] ram_data,
    output logic       ram_we,
    output logic [3:0] cursor_coluna,
    output logic [1:0] cursor_linha,
    output logic       editando,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int unsigned N_ENTRADAS = 8;
    localparam logic [3:0]  ULTIMA     = 4'(N_COLUNAS - 1);
    localparam logic [1:0]  LINHA_INI  = 2'd2;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        EDITA   = 4'd1,
        LE      = 4'd2,
        ESPERA  = 4'd3,
        ESCREVE = 4'd4,
        LIMPA   = 4'd5,
        FIM     = 4'd15
    } estado_t;

    estado_t                 estado;
    logic [N_ENTRADAS-1:0]   entradas_c;
    logic [N_ENTRADAS-1:0]   entradas_r;
    logic [N_ENTRADAS-1:0]   pulso_c;
    logic [3:0]              contador;
    logic [3:0]              col_prox_c;
    logic [1:0]              linha_prox_c;
    logic                    confirma_ok_c;

    // Rising-edge detection on every level input
    assign entradas_c = {iniciar_edicao, finalizar, limpar, confirma,
                         controle_horizontal, controle_vertical};
    assign pulso_c    = entradas_c & ~entradas_r;

    logic p_v_mais, p_v_menos, p_h_mais, p_h_menos;
    logic p_confirma, p_limpar, p_finalizar, p_iniciar;
    assign {p_iniciar, p_finalizar, p_limpar, p_confirma,
            p_h_menos, p_h_mais, p_v_menos, p_v_mais} = pulso_c;

    assign db_estado = 4'(estado);

    // Saturating cursor movement; opposite presses on one axis cancel
    always_comb begin
        col_prox_c    = cursor_coluna;
        linha_prox_c  = cursor_linha;
        if (p_h_mais && !p_h_menos && cursor_coluna != ULTIMA)
            col_prox_c = cursor_coluna + 4'd1;
        else if (p_h_menos && !p_h_mais && cursor_coluna != 4'd0)
            col_prox_c = cursor_coluna - 4'd1;
        if (p_v_mais && !p_v_menos && cursor_linha != 2'd3)
            linha_prox_c = cursor_linha + 2'd1;
        else if (p_v_menos && !p_v_mais && cursor_linha != 2'd0)
            linha_prox_c = cursor_linha - 2'd1;
        confirma_ok_c = p_confirma && !(PROTEGE_INICIO && cursor_coluna == 4'd0);
    end

    // Control FSM with registered RAM-side and status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado        <= INICIAL;
            entradas_r    <= '0;
            contador      <= 4'd0;
            cursor_coluna <= 4'd0;
            cursor_linha  <= LINHA_INI;
            ram_addr      <= 4'd0;
            ram_data      <= 4'd0;
            ram_we        <= 1'b0;
            editando      <= 1'b0;
            pronto        <= 1'b0;
        end else begin
            entradas_r <= entradas_c;
            case (estado)
                INICIAL: begin
                    if (p_iniciar) begin
                        estado        <= EDITA;
                        cursor_coluna <= 4'd0;
                        cursor_linha  <= LINHA_INI;
                        ram_addr      <= 4'd0;
                        editando      <= 1'b1;
                    end
                end
                EDITA: begin
                    if (p_finalizar) begin
                        estado   <= FIM;
                        editando <= 1'b0;
                        pronto   <= 1'b1;
                    end else if (p_limpar) begin
                        estado   <= LIMPA;
                        contador <= 4'd0;
                        ram_addr <= 4'd0;
                        ram_data <= 4'd0;
                        ram_we   <= 1'b1;
                    end else if (confirma_ok_c) begin
                        estado   <= LE;
                        ram_addr <= cursor_coluna;
                    end else begin
                        cursor_coluna <= col_prox_c;
                        cursor_linha  <= linha_prox_c;
                        ram_addr      <= col_prox_c;
                    end
                end
                // Address held while the RAM produces its read data
                LE: estado <= ESPERA;
                // Capture the read word already toggled at the cursor lane
                ESPERA: begin
                    ram_data <= q_ram ^ 4'(4'b0001 << cursor_linha);
                    ram_we   <= 1'b1;
                    estado   <= ESCREVE;
                end
                ESCREVE: begin
                    ram_we <= 1'b0;
                    estado <= EDITA;
                end
                // One zero write per column; ram_addr tracks the counter
                LIMPA: begin
                    if (contador == ULTIMA) begin
                        contador <= 4'd0;
                        ram_we   <= 1'b0;
                        ram_addr <= cursor_coluna;
                        estado   <= EDITA;
                    end else begin
                        contador <= contador + 4'd1;
                        ram_addr <= contador + 4'd1;
                    end
                end
                FIM: begin
                    if (p_iniciar) begin
                        estado        <= EDITA;
                        cursor_coluna <= 4'd0;
                        cursor_linha  <= LINHA_INI;
                        ram_addr      <= 4'd0;
                        editando      <= 1'b1;
                        pronto        <= 1'b0;
                    end
                end
                default: begin
                    estado   <= INICIAL;
                    ram_we   <= 1'b0;
                    editando <= 1'b0;
                    pronto   <= 1'b0;
                end
            endcase
        end
    end

endmodule
